// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/EX status in, pipeline-register controls and counters out.
interface pipe_hazard_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs1_idx;
   logic [4:0]  id_rs2_idx;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic        ex_valid;
   logic [4:0]  ex_rd_idx;
   logic        ex_is_load;
   logic        ex_is_mc;
   logic        mc_done;
   logic        ex_redirect;
   logic        pc_en;
   logic        if_id_en;
   logic        if_id_flush;
   logic        id_ex_en;
   logic        id_ex_flush;
   logic        ex_hold;
   logic        mc_timeout;
   logic        ctrl_state;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   modport master (
      output id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_rd_idx, ex_is_load, ex_is_mc, mc_done, ex_redirect,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_hold,
             mc_timeout, ctrl_state, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_rd_idx, ex_is_load, ex_is_mc, mc_done, ex_redirect,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_hold,
             mc_timeout, ctrl_state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / redirect / multi-cycle stall control for the 5-stage pipeline.
// Perf counters built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int MC_MAX_CYCLES = 64
) (
   input logic clk,
   input logic rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int CW = $clog2(MC_MAX_CYCLES + 1);
   typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] mc_cnt, mc_cnt_nxt;
   logic mc_timeout, set_timeout, load_use;
   assign load_use = bus.ex_valid & bus.ex_is_load & (bus.ex_rd_idx != 5'd0) & bus.id_valid &
                     ((bus.id_uses_rs1 & (bus.id_rs1_idx == bus.ex_rd_idx)) |
                      (bus.id_uses_rs2 & (bus.id_rs2_idx == bus.ex_rd_idx)));
   always_comb begin
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.id_ex_en    = 1'b1;
      bus.if_id_flush = 1'b0;
      bus.id_ex_flush = 1'b0;
      bus.ex_hold     = 1'b0;
      state_nxt       = state;
      mc_cnt_nxt      = mc_cnt;
      set_timeout     = 1'b0;
      if (state == RUN) begin
         if (bus.ex_redirect) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
         end else if (bus.ex_valid & bus.ex_is_mc & ~bus.mc_done) begin
            bus.pc_en    = 1'b0;
            bus.if_id_en = 1'b0;
            bus.id_ex_en = 1'b0;
            bus.ex_hold  = 1'b1;
            state_nxt    = MC_WAIT;
            mc_cnt_nxt   = CW'(1);
         end else if (load_use) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
         end
      end else if (bus.mc_done || mc_cnt == CW'(MC_MAX_CYCLES - 1)) begin
         // natural or forced release: the pipeline resumes this cycle
         state_nxt   = RUN;
         mc_cnt_nxt  = '0;
         set_timeout = ~bus.mc_done;
      end else begin
         bus.pc_en    = 1'b0;
         bus.if_id_en = 1'b0;
         bus.id_ex_en = 1'b0;
         bus.ex_hold  = 1'b1;
         mc_cnt_nxt   = mc_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         mc_cnt     <= '0;
         mc_timeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         mc_cnt     <= mc_cnt_nxt;
         mc_timeout <= mc_timeout | set_timeout;
      end
   end
   assign bus.mc_timeout = mc_timeout;
   assign bus.ctrl_state = state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.stall_cnt <= '0;
         bus.flush_cnt <= '0;
      end else begin
         if (!bus.pc_en && bus.stall_cnt != 32'hFFFF_FFFF) bus.stall_cnt <= bus.stall_cnt + 32'd1;
         if (bus.if_id_flush && bus.flush_cnt != 32'hFFFF_FFFF) bus.flush_cnt <= bus.flush_cnt + 32'd1;
      end
   end
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench; expected control vectors queued at drive time, popped at sample time.
module tb_pipe_hazard_ctrl;
   // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_hold, ctrl_state, mc_timeout}
   localparam logic [7:0] RUNV = 8'b1110_0000;
   localparam logic [7:0] LDU  = 8'b0010_1000;
   localparam logic [7:0] RDR  = 8'b1111_1000;
   localparam logic [7:0] MCS  = 8'b0000_0100;
   localparam logic [7:0] MCW  = 8'b0000_0110;
   localparam logic [7:0] REL  = 8'b1110_0010;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   pipe_hazard_ctrl_if bus();
   pipe_hazard_ctrl #(.MC_MAX_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step(input string tag, input logic r, idv, input logic [4:0] rs1, rs2,
                       input logic u1, u2, exv, input logic [4:0] rd,
                       input logic ld, mc, done, redir, input logic [7:0] e);
      @(negedge clk);
      rst_n = r;
      bus.id_valid = idv; bus.id_rs1_idx = rs1; bus.id_rs2_idx = rs2;
      bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
      bus.ex_valid = exv; bus.ex_rd_idx = rd; bus.ex_is_load = ld;
      bus.ex_is_mc = mc; bus.mc_done = done; bus.ex_redirect = redir;
      exp_q.push_back(e);
      #2;
      if (exp_q.size() == 0) chk({tag, "_q"}, 32'd0, 32'd1);
      else chk(tag, {24'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.if_id_flush,
                     bus.id_ex_flush, bus.ex_hold, bus.ctrl_state, bus.mc_timeout}, {24'd0, exp_q.pop_front()});
   endtask
   task automatic idle(input string tag, input logic [7:0] e);
      step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
   endtask
   task automatic chk_cnt(input string tag, input int s, input int f);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk({tag, "_stall"}, bus.stall_cnt, s);
      chk({tag, "_flush"}, bus.flush_cnt, f);
`else
      chk({tag, "_stall"}, bus.stall_cnt, 32'd0 & s);
      chk({tag, "_flush"}, bus.flush_cnt, 32'd0 & f);
`endif
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      step("reset", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUNV);
      chk_cnt("reset", 0, 0);
      idle("post_reset", RUNV);
      step("ldu_rs2", 1'b1, 1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LDU);
      step("ldu_after", 1'b1, 1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUNV);
      chk_cnt("ldu", 1, 0);
      step("ld_x0", 1'b1, 1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RUNV);
      step("ld_nouse", 1'b1, 1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, RUNV);
      step("rdr_ldu", 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, RDR);
      idle("rdr_after", RUNV);
      chk_cnt("rdr", 1, 1);
      step("mc_c1", 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, MCS);
      step("mc_c2", 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, MCW);
      step("mc_c3_rdr", 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, MCW);
      step("mc_c4_done", 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, REL);
      idle("mc_after", RUNV);
      chk_cnt("mc", 4, 1);
      step("to_c1", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, MCS);
      for (int i = 2; i <= 7; i++)
         step($sformatf("to_c%0d", i), 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, MCW);
      step("to_c8_rel", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, REL);
      idle("to_sticky", RUNV | 8'd1);
      step("to_ldu", 1'b1, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LDU | 8'd1);
      idle("to_after", RUNV | 8'd1);
      chk_cnt("to", 12, 1);
      step("rst_mc_c1", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, MCS | 8'd1);
      step("rst_mc_w1", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, MCW | 8'd1);
      step("rst_mid", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, MCS);
      chk_cnt("rst_mid", 0, 0);
      idle("rst_rel", RUNV);
      step("mc_first", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, RUNV);
      idle("mc_first_after", RUNV);
      chk_cnt("end", 0, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline. It drives the enable and flush controls of the IF/ID and ID/EX pipeline registers, the PC enable, and the EX-stage hold. It resolves three cases: load-use hazards, taken-branch redirects, and multi-cycle EX operations such as divide. It sits beside the decode stage and sequences the ID/EX register without modifying the register itself.

## Interface
- `MC_MAX_CYCLES`, default 64: maximum cycles a multi-cycle op may hold EX before a forced release.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage holds a valid instruction.
- `id_rs1_idx`, `id_rs2_idx` in 5 each: source register indices in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: ID instruction reads rs1 / rs2.
- `ex_valid` in 1: EX stage holds a valid instruction.
- `ex_rd_idx` in 5: destination register index in EX.
- `ex_is_load` in 1: EX instruction is a load.
- `ex_is_mc` in 1: EX instruction is multi-cycle.
- `mc_done` in 1: multi-cycle unit result is ready this cycle.
- `ex_redirect` in 1: a taken branch or jump resolved in EX.
- `pc_en` out 1: PC register update enable.
- `if_id_en` out 1: IF/ID capture enable.
- `if_id_flush` out 1: IF/ID loads a NOP (all zero).
- `id_ex_en` out 1: ID/EX capture enable.
- `id_ex_flush` out 1: ID/EX loads a bubble (all zero).
- `ex_hold` out 1: EX stage must keep its operands and control.
- `mc_timeout` out 1: sticky flag, set when a forced release has occurred.
- `ctrl_state` out 1: current state (0=RUN, 1=MC_WAIT).
- `stall_cnt` out 32: performance counter (see Configuration).
- `flush_cnt` out 32: performance counter (see Configuration).

## Operation
- The FSM has two states, RUN and MC_WAIT. There is also a wait counter `mc_cnt` of width `$clog2(MC_MAX_CYCLES+1)`.
- All control outputs are combinational from the current state and the inputs. The state, `mc_cnt`, `mc_timeout` and the perf counters are registered.
- A flush dominates an enable: when a flush is 1, the corresponding register captures zero regardless of its enable.
- Load-use hazard is true when all of the following hold:
  - `ex_valid & ex_is_load & ex_rd_idx!=0 & id_valid`, and
  - `(id_uses_rs1 & id_rs1_idx==ex_rd_idx) | (id_uses_rs2 & id_rs2_idx==ex_rd_idx)`.
- In RUN, evaluate in priority order:
  1. `ex_redirect`: `if_id_flush=1`, `id_ex_flush=1`, `pc_en=1`, `if_id_en=1`, `id_ex_en=1`. The load-use hazard is ignored that cycle.
  2. `ex_valid & ex_is_mc & !mc_done`: `pc_en=if_id_en=id_ex_en=0`, `ex_hold=1`. Next state is MC_WAIT, `mc_cnt` is set to 1.
  3. Load-use hazard: `pc_en=0`, `if_id_en=0`, `id_ex_en=1`, `id_ex_flush=1`. This inserts exactly one bubble; the following cycle relies on MEM→EX forwarding.
  4. Otherwise: all enables are 1, all flushes are 0, `ex_hold=0`.
- A multi-cycle op with `mc_done` asserted in its first EX cycle causes no stall and stays in RUN.
- In MC_WAIT:
  - If `mc_done`: release this cycle (all enables 1, `ex_hold=0`, no flush). Next state is RUN, `mc_cnt` is cleared to 0.
  - Else if `mc_cnt==MC_MAX_CYCLES-1`: force the same release, set `mc_timeout` (it stays set until reset). Next state is RUN.
  - Else: `pc_en=if_id_en=id_ex_en=0`, `ex_hold=1`, and `mc_cnt` increments.
  - `ex_redirect` and the load-use hazard are ignored in MC_WAIT.

## Timing
- Reset (`rst_n=0`, asynchronous): state=RUN, `mc_cnt=0`, `mc_timeout=0`, `stall_cnt=0`, `flush_cnt=0`, `ctrl_state=0`.
- During reset with all inputs 0, the outputs are `pc_en=if_id_en=id_ex_en=1` and flushes=0, `ex_hold=0`.
- Reset asserted mid-MC_WAIT returns the FSM to RUN immediately; `mc_cnt` and `mc_timeout` clear.
- Load-use stall latency is exactly 1 cycle.
- Redirect penalty is 2 squashed instructions (the IF/ID and ID/EX contents).
- A multi-cycle op stalls for N-1 cycles after its first EX cycle, where N is the cycle index at which `mc_done` arrives (N=1 means no stall). The stall is bounded at `MC_MAX_CYCLES` total cycles.
- Control outputs change in the same cycle as the inputs. Registered elements update on the rising `clk` edge.

## Configuration
- Macro `PIPE_HAZARD_CTRL_PERF_EN`.
- Defined:
  - `stall_cnt` increments on every cycle with `pc_en==0`.
  - `flush_cnt` increments on every cycle with `if_id_flush==1`.
  - Both are 32-bit and saturate at `32'hFFFF_FFFF`.
- Undefined: no counter flops are built, and `stall_cnt`/`flush_cnt` are tied to 0.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with `id_uses_rs2=1` → one cycle of `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`; the next cycle has all enables 1.
- Load with `ex_rd_idx=0`, ID rs1=0 → no stall. Load x5 in EX while the ID instruction has `id_uses_rs1=0` and rs1=5 → no stall.
- `ex_redirect=1` together with a concurrent load-use hazard → `if_id_flush=id_ex_flush=1`, `pc_en=1`; `flush_cnt` +1 with PERF_EN.
- Multi-cycle op with `mc_done` on the 4th EX cycle → `ex_hold=1` and enables 0 for 3 cycles, release in the 4th; `ctrl_state` sequence 0,1,1,1,0; `stall_cnt=3` with PERF_EN.
- `MC_MAX_CYCLES=8`, `mc_done` never asserted → forced release in cycle 8, `mc_timeout=1` and stays 1. A subsequent load-use behaves normally.
- Assert `rst_n=0` on the 2nd MC_WAIT cycle → `ctrl_state=0`, `mc_timeout=0`, counters 0 immediately. After release, a multi-cycle op with `mc_done` in its first cycle → no stall.
